uart_link_tester: RTL and testbench

Parametrised UART link self-test engine, successor to the fixed 8-bit incrementing loopback check in the board top.
- Drives a uart_tx-style transmitter and watches a uart_rx-style receiver.
- Generates selectable test patterns and counts frames, mismatches, parity errors and timeouts.
- Runs bursts or continuously.
- Exposes status flags that the board top maps to LEDs (the top handles the active-low inversion).

---
 rtl/uart_link_tester_if.sv | 21 ++
 rtl/uart_link_tester.sv | 177 +++++++++++++++++
 tb/tb_uart_link_tester.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_link_tester_if.sv
// UART-side handshake between the link tester (master) and the transmitter/receiver pair (slave).
interface uart_link_tester_if #(
  parameter int unsigned DATA_W = 8
);
  logic              start_tx;
  logic [DATA_W-1:0] data_to_tx;
  logic              tx_busy;
  logic              rx_done;
  logic [DATA_W-1:0] data_received;
  logic              parity_error;

  modport master (
    output start_tx, data_to_tx,
    input  tx_busy, rx_done, data_received, parity_error
  );

  modport slave (
    input  start_tx, data_to_tx,
    output tx_busy, rx_done, data_received, parity_error
  );
endinterface

// File: rtl/uart_link_tester.sv
// UART link self-test engine: sends pattern frames, checks the echo, keeps saturating statistics.
// Optional first-error capture outputs are enabled by defining UART_LT_ERR_CAPTURE_EN.
module uart_link_tester #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       CNT_W       = 16,
  parameter int unsigned       NUM_FRAMES  = 0,
  parameter int unsigned       TIMEOUT_CYC = 4800,
  parameter int unsigned       GAP_CYC     = 16,
  parameter logic [DATA_W-1:0] SEED        = '0,
  parameter logic [DATA_W-1:0] LFSR_TAPS   = DATA_W'('hB8)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  uart_link_tester_if.master  link,
  output logic [CNT_W-1:0]    frames_sent,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    timeout_count,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail
`ifdef UART_LT_ERR_CAPTURE_EN
  ,
  output logic [DATA_W-1:0]   first_err_exp,
  output logic [DATA_W-1:0]   first_err_got,
  output logic [CNT_W-1:0]    first_err_idx,
  output logic                first_err_valid
`endif
);

  localparam int unsigned WaitW   = $clog2(TIMEOUT_CYC);
  localparam int unsigned GapLast = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
  localparam int unsigned GapW    = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

  typedef enum logic [2:0] {StIdle, StSend, StWaitRx, StGap, StDone} state_e;

  state_e             state_q;
  logic [1:0]         mode_q;
  logic [DATA_W-1:0]  data_q;
  logic               start_q;
  logic [CNT_W-1:0]   frames_q, err_q, tmo_q;
  logic [WaitW-1:0]   wait_q;
  logic [GapW-1:0]    gap_q;
  logic [DATA_W-1:0]  seed_fixed;
  logic               rx_bad;
`ifdef UART_LT_ERR_CAPTURE_EN
  logic [DATA_W-1:0]  cap_exp_q, cap_got_q;
  logic [CNT_W-1:0]   cap_idx_q;
  logic               cap_valid_q;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] next_pattern(input logic [1:0] m,
                                                     input logic [DATA_W-1:0] v);
    case (m)
      2'd1:    return {v[DATA_W-2:0], v[DATA_W-1]};
      2'd2:    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
      default: return v + 1'b1;
    endcase
  endfunction

  // An all-zero seed would lock walking-one and LFSR patterns at zero.
  assign seed_fixed = (SEED == '0 && (mode == 2'd1 || mode == 2'd2)) ? DATA_W'(1) : SEED;
  assign rx_bad     = (link.data_received != data_q) || link.parity_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mode_q   <= 2'd0;
      data_q   <= '0;
      start_q  <= 1'b0;
      frames_q <= '0;
      err_q    <= '0;
      tmo_q    <= '0;
      wait_q   <= '0;
      gap_q    <= '0;
`ifdef UART_LT_ERR_CAPTURE_EN
      cap_exp_q   <= '0;
      cap_got_q   <= '0;
      cap_idx_q   <= '0;
      cap_valid_q <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            frames_q <= '0;
            err_q    <= '0;
            tmo_q    <= '0;
            mode_q   <= mode;
            data_q   <= seed_fixed;
            state_q  <= StSend;
`ifdef UART_LT_ERR_CAPTURE_EN
            cap_exp_q   <= '0;
            cap_got_q   <= '0;
            cap_idx_q   <= '0;
            cap_valid_q <= 1'b0;
`endif
          end
        end
        StSend: begin
          if (!link.tx_busy) begin
            start_q  <= 1'b1;
            frames_q <= sat_inc(frames_q);
            wait_q   <= '0;
            state_q  <= StWaitRx;
          end
        end
        StWaitRx: begin
          // A response landing on the final wait cycle still counts as received.
          if (link.rx_done) begin
            if (rx_bad) begin
              err_q <= sat_inc(err_q);
`ifdef UART_LT_ERR_CAPTURE_EN
              if (!cap_valid_q) begin
                cap_exp_q   <= data_q;
                cap_got_q   <= link.data_received;
                cap_idx_q   <= frames_q;
                cap_valid_q <= 1'b1;
              end
`endif
            end
            gap_q   <= '0;
            state_q <= StGap;
          end else if (wait_q == WaitW'(TIMEOUT_CYC - 1)) begin
            tmo_q   <= sat_inc(tmo_q);
            gap_q   <= '0;
            state_q <= StGap;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_q == GapW'(GapLast)) begin
            if (NUM_FRAMES != 0 && frames_q == CNT_W'(NUM_FRAMES)) begin
              state_q <= StDone;
            end else if (!enable) begin
              state_q <= StIdle;
            end else begin
              data_q  <= next_pattern(mode_q, data_q);
              state_q <= StSend;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        StDone: begin
          if (!enable) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign link.start_tx   = start_q;
  assign link.data_to_tx = data_q;
  assign frames_sent     = frames_q;
  assign err_count       = err_q;
  assign timeout_count   = tmo_q;
  assign busy            = (state_q != StIdle) && (state_q != StDone);
  assign done            = (state_q == StDone);
  assign pass            = (frames_q != '0) && (err_q == '0) && (tmo_q == '0);
  assign fail            = (err_q != '0) || (tmo_q != '0);
`ifdef UART_LT_ERR_CAPTURE_EN
  assign first_err_exp   = cap_exp_q;
  assign first_err_got   = cap_got_q;
  assign first_err_idx   = cap_idx_q;
  assign first_err_valid = cap_valid_q;
`endif

endmodule

// File: tb/tb_uart_link_tester.sv
// Bench for uart_link_tester: two instances (burst and continuous) driven by loopback responders.
module tb_uart_link_tester;
  localparam int unsigned TMO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, en_a, en_b;
  logic [1:0] mode_a, mode_b;
  logic [15:0] fs_a, ec_a, tc_a, fs_b, ec_b, tc_b;
  logic       busy_a, done_a, pass_a, fail_a, busy_b, done_b, pass_b, fail_b;
`ifdef UART_LT_ERR_CAPTURE_EN
  logic [7:0]  fexp_a, fgot_a, fexp_b, fgot_b;
  logic [15:0] fidx_a, fidx_b;
  logic        fval_a, fval_b;
`endif

  uart_link_tester_if #(.DATA_W(8)) if_a ();
  uart_link_tester_if #(.DATA_W(8)) if_b ();

  uart_link_tester #(
    .DATA_W(8), .CNT_W(16), .NUM_FRAMES(4), .TIMEOUT_CYC(TMO), .GAP_CYC(3),
    .SEED(8'hFE), .LFSR_TAPS(8'hB8)
  ) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .mode(mode_a), .link(if_a.master),
    .frames_sent(fs_a), .err_count(ec_a), .timeout_count(tc_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a)
`ifdef UART_LT_ERR_CAPTURE_EN
    , .first_err_exp(fexp_a), .first_err_got(fgot_a), .first_err_idx(fidx_a),
    .first_err_valid(fval_a)
`endif
  );

  uart_link_tester #(
    .DATA_W(8), .CNT_W(16), .NUM_FRAMES(0), .TIMEOUT_CYC(TMO), .GAP_CYC(0),
    .SEED(8'h00), .LFSR_TAPS(8'hB8)
  ) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .mode(mode_b), .link(if_b.master),
    .frames_sent(fs_b), .err_count(ec_b), .timeout_count(tc_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b)
`ifdef UART_LT_ERR_CAPTURE_EN
    , .first_err_exp(fexp_b), .first_err_got(fgot_b), .first_err_idx(fidx_b),
    .first_err_valid(fval_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Per-frame responder behaviour, indexed by frame number within the run.
  int         dly_a[16], dly_b[16];
  logic [7:0] xr_a[16], xr_b[16];
  logic       par_a[16], par_b[16];
  int         n_a = 0, n_b = 0;
  logic [7:0] seq_a[$], seq_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected k-th frame (0-based) of a run, straight from the pattern definitions.
  function automatic logic [7:0] pat(input logic [1:0] m, input logic [7:0] seed, input int k);
    logic [7:0]  v;
    logic [15:0] w;
    v = (seed == 8'h00 && (m == 2'd1 || m == 2'd2)) ? 8'h01 : seed;
    if (m == 2'd1) begin
      w = {v, v} << (k % 8);
      v = w[15:8];
    end else if (m == 2'd2) begin
      for (int i = 0; i < k; i++) v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    end else begin
      v = 8'((int'(v) + k) % 256);
    end
    return v;
  endfunction

  task automatic clr_a();
    for (int i = 0; i < 16; i++) begin
      dly_a[i] = int'($urandom_range(TMO - 2, 2));
      xr_a[i]  = 8'h00;
      par_a[i] = 1'b0;
    end
    n_a = 0;
    seq_a.delete();
  endtask

  task automatic clr_b();
    for (int i = 0; i < 16; i++) begin
      dly_b[i] = int'($urandom_range(TMO - 2, 2));
      xr_b[i]  = 8'h00;
      par_b[i] = 1'b0;
    end
    n_b = 0;
    seq_b.delete();
  endtask

  task automatic wait_done_a(input string tag);
    int cyc = 0;
    while (done_a !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 32'(done_a), 32'd1);
  endtask

  task automatic wait_seq_b(input int n, input string tag);
    int cyc = 0;
    while (seq_b.size() < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 32'(seq_b.size() >= n), 32'd1);
  endtask

  task automatic wait_idle_b(input string tag);
    int cyc = 0;
    while (busy_b !== 1'b0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 32'(busy_b), 32'd0);
  endtask

  // Loopback responders: rx_done lands dly cycles after the start_tx cycle.
  initial begin : resp_a
    int k;
    logic [7:0] d;
    if_a.rx_done = 1'b0;
    if_a.data_received = 8'h00;
    if_a.parity_error = 1'b0;
    forever begin
      @(negedge clk);
      if (if_a.start_tx === 1'b1) begin
        k = (n_a < 16) ? n_a : 15;
        d = if_a.data_to_tx;
        seq_a.push_back(d);
        n_a++;
        repeat (dly_a[k]) @(negedge clk);
        if_a.rx_done = 1'b1;
        if_a.data_received = d ^ xr_a[k];
        if_a.parity_error = par_a[k];
        @(negedge clk);
        if_a.rx_done = 1'b0;
        if_a.parity_error = 1'b0;
      end
    end
  end

  initial begin : resp_b
    int k;
    logic [7:0] d;
    if_b.rx_done = 1'b0;
    if_b.data_received = 8'h00;
    if_b.parity_error = 1'b0;
    forever begin
      @(negedge clk);
      if (if_b.start_tx === 1'b1) begin
        k = (n_b < 16) ? n_b : 15;
        d = if_b.data_to_tx;
        seq_b.push_back(d);
        n_b++;
        repeat (dly_b[k]) @(negedge clk);
        if_b.rx_done = 1'b1;
        if_b.data_received = d ^ xr_b[k];
        if_b.parity_error = par_b[k];
        @(negedge clk);
        if_b.rx_done = 1'b0;
        if_b.parity_error = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [1:0] m;
    int c, p, f, hi;
    logic [7:0] mask, fe;

    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0;
    if_a.tx_busy = 1'b0; if_b.tx_busy = 1'b0;
    clr_a(); clr_b();
    repeat (3) @(negedge clk);

    chk("rst_flags", 32'({if_a.start_tx, busy_a, done_a, pass_a, fail_a}), 32'd0);
    chk("rst_data", 32'(if_a.data_to_tx), 32'd0);
    chk("rst_counts", 32'({fs_a, ec_a}), 32'd0);
    chk("rst_tmo", 32'(tc_a), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Burst, mode 0, with tx_busy held for 50 cycles at SEND entry.
    clr_a();
    mode_a = 2'd0;
    if_a.tx_busy = 1'b1;
    en_a = 1'b1;
    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (if_a.start_tx === 1'b1) hi++;
    end
    chk("busy_hold_no_start", 32'(hi), 32'd0);
    chk("busy_flag_running", 32'(busy_a), 32'd1);
    if_a.tx_busy = 1'b0;
    @(negedge clk);
    chk("start_after_busy", 32'(if_a.start_tx), 32'd1);
    @(negedge clk);
    chk("start_one_cycle", 32'(if_a.start_tx), 32'd0);
    wait_done_a("a1_reach_done");
    chk("a1_nframes", 32'(seq_a.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk("a1_seq", 32'(seq_a[k]), 32'(pat(2'd0, 8'hFE, k)));
    chk("a1_frames_sent", 32'(fs_a), 32'd4);
    chk("a1_err_tmo", 32'({ec_a, tc_a}), 32'd0);
    chk("a1_pass_fail_busy", 32'({pass_a, fail_a, busy_a}), 32'b100);
    en_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("a1_idle_flags", 32'({done_a, busy_a}), 32'd0);
    chk("a1_idle_held", 32'(fs_a), 32'd4);

    // Burst with one corrupted frame and one parity error, random mode.
    clr_a();
    m = 2'($urandom_range(3, 0));
    c = int'($urandom_range(4, 1));
    p = int'($urandom_range(4, 1));
    mask = 8'($urandom_range(255, 1));
    xr_a[c-1] = mask;
    par_a[p-1] = 1'b1;
    mode_a = m;
    en_a = 1'b1;
    @(negedge clk);
    mode_a = ~m;
    wait_done_a("a2_reach_done");
    for (int k = 0; k < 4; k++) chk("a2_seq", 32'(seq_a[k]), 32'(pat(m, 8'hFE, k)));
    chk("a2_err_count", 32'(ec_a), (c == p) ? 32'd1 : 32'd2);
    chk("a2_tmo", 32'(tc_a), 32'd0);
    chk("a2_pass_fail", 32'({pass_a, fail_a}), 32'b01);
`ifdef UART_LT_ERR_CAPTURE_EN
    f = (c < p) ? c : p;
    fe = pat(m, 8'hFE, f - 1);
    chk("a2_cap_idx", 32'(fidx_a), 32'(f));
    chk("a2_cap_exp", 32'(fexp_a), 32'(fe));
    chk("a2_cap_got", 32'(fgot_a), 32'(fe ^ ((f == c) ? mask : 8'h00)));
    chk("a2_cap_valid", 32'(fval_a), 32'd1);
`endif
    en_a = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1 answers one cycle too late (inside GAP), frame 2 on the last wait cycle.
    clr_a();
    dly_a[0] = TMO;
    xr_a[0]  = 8'h55;
    dly_a[1] = TMO - 1;
    mode_a = 2'd0;
    en_a = 1'b1;
    wait_done_a("a3_reach_done");
    chk("a3_tmo", 32'(tc_a), 32'd1);
    chk("a3_err", 32'(ec_a), 32'd0);
    chk("a3_frames_sent", 32'(fs_a), 32'd4);
    chk("a3_pass_fail", 32'({pass_a, fail_a}), 32'b01);
`ifdef UART_LT_ERR_CAPTURE_EN
    chk("a3_cap_cleared", 32'({fval_a, fidx_a}), 32'd0);
`endif
    en_a = 1'b0;
    repeat (2) @(negedge clk);

    // Continuous LFSR run, enable dropped during WAIT_RX of frame 3.
    clr_b();
    mode_b = 2'd2;
    en_b = 1'b1;
    wait_seq_b(3, "b1_three_frames");
    en_b = 1'b0;
    wait_idle_b("b1_reach_idle");
    chk("b1_nframes", 32'(seq_b.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk("b1_seq", 32'(seq_b[k]), 32'(pat(2'd2, 8'h00, k)));
    chk("b1_counts", 32'(fs_b), 32'd3);
    chk("b1_err_tmo", 32'({ec_b, tc_b}), 32'd0);
    chk("b1_flags", 32'({done_b, pass_b, fail_b}), 32'b010);

    // Continuous walking-one run from a zero seed.
    clr_b();
    mode_b = 2'd1;
    en_b = 1'b1;
    wait_seq_b(3, "b2_three_frames");
    en_b = 1'b0;
    wait_idle_b("b2_reach_idle");
    for (int k = 0; k < 3; k++) chk("b2_seq", 32'(seq_b[k]), 32'(pat(2'd1, 8'h00, k)));
    chk("b2_counts", 32'(fs_b), 32'd3);

    // Reset asserted while start_tx is high, mid-run.
    clr_b();
    mode_b = 2'($urandom_range(3, 0));
    en_b = 1'b1;
    wait_seq_b(1, "b3_first_frame");
    hi = 0;
    while (if_b.start_tx !== 1'b1 && hi < 2000) begin
      @(negedge clk);
      hi++;
    end
    chk("b3_second_start", 32'(if_b.start_tx), 32'd1);
    #1 rst_b = 1'b1;
    #1;
    chk("b3_rst_start", 32'(if_b.start_tx), 32'd0);
    chk("b3_rst_data", 32'(if_b.data_to_tx), 32'd0);
    chk("b3_rst_counts", 32'({fs_b, ec_b}), 32'd0);
    chk("b3_rst_flags", 32'({tc_b, busy_b, done_b, pass_b, fail_b}), 32'd0);
    en_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
